// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// access-mode codes, slot-state encoding and the latched slot record.
package mem_arb_pkg;

  localparam logic [2:0] MODE_BYTE = 3'd1;
  localparam logic [2:0] MODE_WORD = 3'd2;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_I    = 2'd1,
    SLOT_D    = 2'd2
  } slot_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mode;
    logic        write;
  } slot_t;

endpackage

// File: rtl/mem_arbiter_arb_priority.sv
// Data-first grant logic with a saturating starvation counter that forces a
// pending fetch through after STARVE_LIMIT consecutive data grants.
module arb_priority #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic iReq,
  input  logic dReq,
  output logic iGnt,
  output logic dGnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;
  logic       w_force;

  assign w_force = (r_starve == LIMIT) && iReq;
  assign dGnt    = dReq && !w_force;
  assign iGnt    = iReq && (!dReq || w_force);

  // A fetch that is not waiting cannot be starved, so the count only runs while iReq is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= 4'd0;
    end else if (!iReq || iGnt) begin
      r_starve <= 4'd0;
    end else if (dGnt && (r_starve != LIMIT)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between fetch and load/store through a
// one-cycle access slot; results return to the owner one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iReq,
  input  logic [31:0] iAddress,
  output logic        iGnt,
  output logic        iValid,
  output logic [31:0] iData,
  input  logic        dReq,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic [2:0]  dMode,
  input  logic        dWrite,
  output logic        dGnt,
  output logic        dValid,
  output logic [31:0] dData,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [2:0]  memMode,
  output logic        memWrite,
  output logic        memRead,
  input  logic [31:0] memReadData
);

  slot_state_t r_state;
  slot_state_t w_stateNext;
  slot_t       r_slot;
  slot_t       w_slotNext;
  logic        w_iGnt;
  logic        w_dGnt;
  logic        r_iValid;
  logic        r_dValid;
  logic [31:0] r_iData;
  logic [31:0] r_dData;

  arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arbPriority (
    .clk  (clk),
    .reset(reset),
    .iReq (iReq),
    .dReq (dReq),
    .iGnt (w_iGnt),
    .dGnt (w_dGnt)
  );

  assign iGnt   = w_iGnt;
  assign dGnt   = w_dGnt;
  assign iValid = r_iValid;
  assign iData  = r_iData;
  assign dValid = r_dValid;
  assign dData  = r_dData;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SLOT_IDLE;
      r_slot  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_slot  <= w_slotNext;
    end
  end

  // The grants are mutually exclusive, so at most one branch loads the slot.
  always_comb begin
    w_stateNext = SLOT_IDLE;
    w_slotNext  = r_slot;
    if (w_dGnt) begin
      w_stateNext = SLOT_D;
      w_slotNext  = '{addr: dAddress, wdata: dWriteData, mode: dMode, write: dWrite};
    end else if (w_iGnt) begin
      w_stateNext = SLOT_I;
      w_slotNext  = '{addr: iAddress, wdata: 32'd0, mode: MODE_WORD, write: 1'b0};
    end
  end

  always_comb begin
    memAddress   = 32'd0;
    memWriteData = 32'd0;
    memMode      = 3'd0;
    memWrite     = 1'b0;
    memRead      = 1'b0;
    case (r_state)
      SLOT_I: begin
        memAddress = r_slot.addr;
        memMode    = MODE_WORD;
        memRead    = 1'b1;
      end
      SLOT_D: begin
        memAddress = r_slot.addr;
        memMode    = r_slot.mode;
        if (r_slot.write) begin
          memWrite     = 1'b1;
          memWriteData = r_slot.wdata;
        end else begin
          memRead = 1'b1;
        end
      end
      default: begin
        memRead = 1'b0;
      end
    endcase
  end

  // Read data is captured at the edge that closes the access cycle; stores report zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iValid <= 1'b0;
      r_dValid <= 1'b0;
      r_iData  <= 32'd0;
      r_dData  <= 32'd0;
    end else begin
      r_iValid <= (r_state == SLOT_I);
      r_dValid <= (r_state == SLOT_D);
      if (r_state == SLOT_I) begin
        r_iData <= memReadData;
      end
      if (r_state == SLOT_D) begin
        r_dData <= r_slot.write ? 32'd0 : memReadData;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant table, scoreboard of returned
// data against a shadow memory, and hand-written latency/reset sequences.
module tb_mem_arbiter;

  localparam logic [2:0] M_BYTE = 3'd1;
  localparam logic [2:0] M_WORD = 3'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        iReq;
  logic [31:0] iAddress;
  logic        iGnt;
  logic        iValid;
  logic [31:0] iData;
  logic        dReq;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [2:0]  dMode;
  logic        dWrite;
  logic        dGnt;
  logic        dValid;
  logic [31:0] dData;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [2:0]  memMode;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic [31:0] dAddr;
    logic [31:0] dWd;
    logic [2:0]  dMode;
    logic        dWrite;
    logic        expI;
    logic        expD;
  } vec_t;

  typedef struct {
    logic        isD;
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t        sb[$];
  vec_t       vecs[16];
  logic [7:0] mem[256];
  logic [7:0] shadow[256];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .iReq        (iReq),
    .iAddress    (iAddress),
    .iGnt        (iGnt),
    .iValid      (iValid),
    .iData       (iData),
    .dReq        (dReq),
    .dAddress    (dAddress),
    .dWriteData  (dWriteData),
    .dMode       (dMode),
    .dWrite      (dWrite),
    .dGnt        (dGnt),
    .dValid      (dValid),
    .dData       (dData),
    .memAddress  (memAddress),
    .memWriteData(memWriteData),
    .memMode     (memMode),
    .memWrite    (memWrite),
    .memRead     (memRead),
    .memReadData (memReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] initByte(int a);
    case (a)
      0:  return 8'h0D;
      1:  return 8'h0C;
      2:  return 8'h0B;
      3:  return 8'h0A;
      4:  return 8'h44;
      5:  return 8'h33;
      6:  return 8'h22;
      7:  return 8'h11;
      8:  return 8'h88;
      9:  return 8'h77;
      10: return 8'h66;
      11: return 8'h55;
      16: return 8'hEF;
      17: return 8'hBE;
      18: return 8'hAD;
      19: return 8'hDE;
      default: return 8'(a * 37 + 11);
    endcase
  endfunction

  function automatic logic [31:0] shRead(logic [31:0] a, logic [2:0] m);
    logic [7:0] b;
    b = a[7:0];
    if (m == M_BYTE) return {{24{shadow[b][7]}}, shadow[b]};
    if (m == M_WORD) return {shadow[8'(b + 8'd3)], shadow[8'(b + 8'd2)], shadow[8'(b + 8'd1)], shadow[b]};
    return 32'd0;
  endfunction

  // Memory model: combinational read (byte reads sign-extend), writes on the falling edge.
  always_comb begin
    logic [7:0] b;
    b = memAddress[7:0];
    memReadData = 32'd0;
    if (memMode == M_BYTE) memReadData = {{24{mem[b][7]}}, mem[b]};
    else if (memMode == M_WORD) memReadData = {mem[8'(b + 8'd3)], mem[8'(b + 8'd2)], mem[8'(b + 8'd1)], mem[b]};
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = initByte(i);
    forever begin
      @(negedge clk);
      if (memWrite) begin
        if (memMode == M_BYTE) begin
          mem[memAddress[7:0]] = memWriteData[7:0];
        end else if (memMode == M_WORD) begin
          for (int k = 0; k < 4; k++) mem[8'(memAddress[7:0] + 8'(k))] = memWriteData[8*k +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    iReq       = v.iReq;
    iAddress   = v.iAddr;
    dReq       = v.dReq;
    dAddress   = v.dAddr;
    dWriteData = v.dWd;
    dMode      = v.dMode;
    dWrite     = v.dWrite;
  endtask

  function automatic vec_t mkVec(logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
                                 logic [31:0] dw, logic [2:0] dm, logic dwr, logic ei, logic ed);
    vec_t v;
    v = '{iReq: ir, iAddr: ia, dReq: dr, dAddr: da, dWd: dw, dMode: dm, dWrite: dwr, expI: ei, expD: ed};
    return v;
  endfunction

  task automatic idleInputs();
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks the memory port against the previous cycle's grant and
  // scores returned data against the shadow memory in acceptance order.
  initial begin
    logic        expRd;
    logic        expWr;
    logic [2:0]  expMode;
    logic [31:0] expAddr;
    logic [31:0] expWd;
    sb_t         e;
    expRd = 0; expWr = 0; expMode = 0; expAddr = 0; expWd = 0;
    for (int i = 0; i < 256; i++) shadow[i] = initByte(i);
    forever begin
      @(negedge clk);
      if (!reset) begin
        expRd = 0; expWr = 0; expMode = 0; expAddr = 0; expWd = 0;
      end
      checkOutput("memRead", 32'(memRead), 32'(expRd));
      checkOutput("memWrite", 32'(memWrite), 32'(expWr));
      checkOutput("memMode", 32'(memMode), 32'(expMode));
      checkOutput("memAddress", memAddress, expAddr);
      checkOutput("memWriteData", memWriteData, expWd);
      checkOutput("grantExclusive", 32'(iGnt && dGnt), 32'd0);
      if (!reset) begin
        checkOutput("resetValid", 32'(iValid | dValid), 32'd0);
        sb.delete();
      end else if (iValid || dValid) begin
        checkOutput("validExclusive", 32'(iValid && dValid), 32'd0);
        checkOutput("unexpectedValid", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("validOwner", 32'(dValid), 32'(e.isD));
          checkOutput("validCycle", 32'(cyc), 32'(e.due));
          checkOutput("validData", dValid ? dData : iData, e.data);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        checkOutput("missingValid", 32'(iValid | dValid), 32'd1);
        void'(sb.pop_front());
      end
      expRd = 0; expWr = 0; expMode = 0; expAddr = 0; expWd = 0;
      if (reset && dGnt) begin
        expAddr = dAddress;
        expMode = dMode;
        if (dWrite) begin
          expWr = 1;
          expWd = dWriteData;
          sb.push_back('{isD: 1'b1, data: 32'd0, due: cyc + 2});
          if (dMode == M_BYTE) begin
            shadow[dAddress[7:0]] = dWriteData[7:0];
          end else if (dMode == M_WORD) begin
            for (int k = 0; k < 4; k++) shadow[8'(dAddress[7:0] + 8'(k))] = dWriteData[8*k +: 8];
          end
        end else begin
          expRd = 1;
          sb.push_back('{isD: 1'b1, data: shRead(dAddress, dMode), due: cyc + 2});
        end
      end else if (reset && iGnt) begin
        expRd   = 1;
        expAddr = iAddress;
        expMode = M_WORD;
        sb.push_back('{isD: 1'b0, data: shRead(iAddress, M_WORD), due: cyc + 2});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fetchExp[3];
    fetchExp[0] = 32'h0A0B0C0D;
    fetchExp[1] = 32'h11223344;
    fetchExp[2] = 32'h55667788;

    // Grant table starting with the starvation counter at zero.
    vecs[0]  = mkVec(1, 32'h0,  0, 32'h0,  32'h0,        M_WORD, 0, 1, 0);
    vecs[1]  = mkVec(0, 32'h0,  1, 32'h10, 32'h0,        M_WORD, 0, 0, 1);
    vecs[2]  = mkVec(1, 32'h4,  1, 32'h13, 32'h0,        M_BYTE, 0, 0, 1);
    vecs[3]  = mkVec(1, 32'h4,  1, 32'h80, 32'hCAFEF00D, M_WORD, 1, 0, 1);
    vecs[4]  = mkVec(1, 32'h4,  1, 32'h80, 32'h0,        M_WORD, 0, 0, 1);
    vecs[5]  = mkVec(1, 32'h4,  1, 32'h10, 32'h0,        3'd3,   0, 0, 1);
    vecs[6]  = mkVec(1, 32'h4,  1, 32'h10, 32'h0,        M_WORD, 0, 1, 0);
    vecs[7]  = mkVec(1, 32'h8,  1, 32'h81, 32'h0,        M_BYTE, 0, 0, 1);
    vecs[8]  = mkVec(1, 32'h8,  1, 32'h80, 32'h0,        M_BYTE, 0, 0, 1);
    vecs[9]  = mkVec(1, 32'h8,  1, 32'h0,  32'h0,        M_WORD, 0, 0, 1);
    vecs[10] = mkVec(1, 32'h8,  1, 32'h10, 32'h0,        M_WORD, 0, 0, 1);
    vecs[11] = mkVec(1, 32'h8,  1, 32'h10, 32'h0,        M_WORD, 0, 1, 0);
    vecs[12] = mkVec(0, 32'h0,  1, 32'h4,  32'h0,        M_WORD, 0, 0, 1);
    vecs[13] = mkVec(0, 32'h0,  0, 32'h0,  32'h0,        M_WORD, 0, 0, 0);
    vecs[14] = mkVec(1, 32'h10, 1, 32'h8,  32'h0,        M_WORD, 0, 0, 1);
    vecs[15] = mkVec(1, 32'h10, 0, 32'h0,  32'h0,        M_WORD, 0, 1, 0);

    reset = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstIValid", 32'(iValid), 32'd0);
    checkOutput("rstDValid", 32'(dValid), 32'd0);
    checkOutput("rstIData", iData, 32'd0);
    checkOutput("rstDData", dData, 32'd0);
    nextCycle();
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.iGnt", i), 32'(iGnt), 32'(vecs[i].expI));
      checkOutput($sformatf("vec%0d.dGnt", i), 32'(dGnt), 32'(vecs[i].expD));
      nextCycle();
    end
    idleInputs();
    repeat (3) nextCycle();

    // Fetch-only latency: grant, access, then data.
    applyStimulus(mkVec(1, 32'h10, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("fetch.iGnt", 32'(iGnt), 32'd1);
    nextCycle();
    idleInputs();
    @(negedge clk);
    checkOutput("fetch.memRead", 32'(memRead), 32'd1);
    checkOutput("fetch.memAddress", memAddress, 32'h10);
    nextCycle();
    @(negedge clk);
    checkOutput("fetch.iValid", 32'(iValid), 32'd1);
    checkOutput("fetch.iData", iData, 32'hDEADBEEF);
    nextCycle();

    // Byte store immediately followed by a byte load of the same address.
    applyStimulus(mkVec(0, 0, 1, 32'h20, 32'h000000A5, M_BYTE, 1, 0, 0));
    @(negedge clk);
    checkOutput("store.dGnt", 32'(dGnt), 32'd1);
    nextCycle();
    applyStimulus(mkVec(0, 0, 1, 32'h20, 32'h0, M_BYTE, 0, 0, 0));
    @(negedge clk);
    checkOutput("store.memWrite", 32'(memWrite), 32'd1);
    checkOutput("load.dGnt", 32'(dGnt), 32'd1);
    nextCycle();
    idleInputs();
    @(negedge clk);
    checkOutput("store.dValid", 32'(dValid), 32'd1);
    checkOutput("store.dData", dData, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("load.dValid", 32'(dValid), 32'd1);
    checkOutput("load.dData", dData, 32'hFFFFFFA5);
    nextCycle();

    // Back-to-back fetches return on consecutive cycles in order.
    for (int k = 0; k < 5; k++) begin
      if (k < 3) applyStimulus(mkVec(1, 32'(4 * k), 0, 0, 0, 0, 0, 0, 0));
      else idleInputs();
      @(negedge clk);
      if (k < 3) checkOutput($sformatf("b2b%0d.iGnt", k), 32'(iGnt), 32'd1);
      if (k >= 2) begin
        checkOutput($sformatf("b2b%0d.iValid", k - 2), 32'(iValid), 32'd1);
        checkOutput($sformatf("b2b%0d.iData", k - 2), iData, fetchExp[k-2]);
      end
      nextCycle();
    end
    repeat (2) nextCycle();

    // Reset during a store access abandons it; a fresh load then completes.
    applyStimulus(mkVec(0, 0, 1, 32'h40, 32'h12345678, M_WORD, 1, 0, 0));
    @(negedge clk);
    checkOutput("abort.dGnt", 32'(dGnt), 32'd1);
    nextCycle();
    reset = 1'b0;
    idleInputs();
    @(negedge clk);
    checkOutput("abort.memWrite", 32'(memWrite), 32'd0);
    checkOutput("abort.memAddress", memAddress, 32'd0);
    checkOutput("abort.dValidEarly", 32'(dValid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("abort.dValid", 32'(dValid), 32'd0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(mkVec(0, 0, 1, 32'h4, 32'h0, M_WORD, 0, 0, 0));
    @(negedge clk);
    checkOutput("fresh.dGnt", 32'(dGnt), 32'd1);
    nextCycle();
    idleInputs();
    nextCycle();
    @(negedge clk);
    checkOutput("fresh.dValid", 32'(dValid), 32'd1);
    checkOutput("fresh.dData", dData, 32'h11223344);
    repeat (3) nextCycle();

    @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data-memory port (byte/word modes, combinational read, write on the falling clock edge) between the instruction-fetch requester and the load/store requester, which enables a unified instruction/data memory. The arbiter accepts one request per cycle and latches it into a one-cycle access slot that drives the memory. It returns read data or write completion to the owning requester one cycle later. Data accesses have priority, and a starvation limit guarantees fetch progress.

## Interface
- STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch is pending before the fetch is forced through (range 1..15).
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- iReq  in  1  fetch request.
- iAddress  in  32  fetch byte address; always word mode.
- iGnt  out  1  combinational: fetch accepted at this rising edge.
- iValid  out  1  registered one-cycle pulse: iData valid.
- iData  out  32  fetched word.
- dReq  in  1  load/store request.
- dAddress  in  32  byte address.
- dWriteData  in  32  store data.
- dMode  in  3  1 = byte, 2 = word; other values pass through and have no effect.
- dWrite  in  1  1 = store, 0 = load.
- dGnt  out  1  combinational: data request accepted at this rising edge.
- dValid  out  1  registered one-cycle pulse: load data valid, or store done.
- dData  out  32  load data; 0 for stores.
- memAddress, memWriteData  out  32  memory port, driven from the slot registers.
- memMode  out  3  memory access mode.
- memWrite, memRead  out  1  memory strobes.
- memReadData  in  32  combinational memory read data.

## Operation
- The slot state is one of IDLE, ACC_I or ACC_D. It is held in a register together with the latched address, write data, mode and write flag.
- Grant rule: dGnt = dReq && !force. iGnt = iReq && (!dReq || force). Both grants are never high together.
- force = (starve == STARVE_LIMIT) && iReq.
- Acceptance: a request is accepted when xReq && xGnt at a rising edge. The slot then loads the request fields and the state becomes ACC_I or ACC_D. If no request is accepted, the state becomes IDLE.
- Requester contract: xReq and its fields stay stable until the rising edge where xGnt = 1. A requester may issue a new request in the very next cycle, so back-to-back accesses are supported.
- In ACC_I: memRead = 1, memWrite = 0, memMode = 2, memAddress = latched iAddress.
- In ACC_D (load): memRead = 1, memWrite = 0, memMode = latched mode.
- In ACC_D (store): memWrite = 1, memRead = 0, memWriteData = latched data.
- In IDLE: all mem outputs are 0.
- Completion: at the rising edge that ends an access cycle, memReadData is registered into the owner's iData or dData, and that owner's xValid pulses for one cycle. For a store, dData = 0.
- Starvation counter (4 bits):
  - increments on each dGnt acceptance while iReq = 1;
  - clears on an iGnt acceptance or when iReq = 0;
  - saturates at STARVE_LIMIT.

## Timing
- Reset values: state IDLE, starve 0, iValid/dValid 0, iData/dData 0, all mem outputs 0.
- Latency: a request accepted at edge E0 is accessed in cycle E0→E1 (a store's write lands on the falling edge mid-cycle). xValid is high in cycle E1→E2.
- Throughput: one access per cycle.
- Simultaneous requests: data wins unless force is set. The losing request stays pending, with its grant low.
- The slot is never overwritten mid-access; a new acceptance replaces it only at the edge where the current access completes.
- Reset asserted mid-access: the access is abandoned, no xValid is produced, and the mem strobes drop immediately.
- Reset deassertion is synchronised by the system; the first acceptance can occur at the first rising edge after release.

## Structure
- Shared package mem_arb_pkg:
  - mode constants MODE_BYTE = 1 and MODE_WORD = 2;
  - slot-state encoding SLOT_IDLE / SLOT_I / SLOT_D.
- One sub-module, arb_priority: holds the starvation counter and produces iGnt/dGnt combinationally from the requests and the counter. The top level contains the slot registers, the mem drive and the completion registers.

## Test plan
- Fetch only: iReq with iAddress = 0x10, memory word 0xDEADBEEF → iGnt in cycle 0, memRead = 1 with memAddress = 0x10 in cycle 1, iValid with iData = 0xDEADBEEF in cycle 2.
- Store then load: byte store 0xA5 to address 0x20, then a byte load from 0x20 in the next cycle → dValid after each; load returns dData = 0xFFFFFFA5 (sign-extended).
- Contention: both request every cycle with STARVE_LIMIT = 4 → grant sequence D, D, D, D, I, D, D, D, D, I …; iGnt and dGnt never high together.
- Back-to-back fetches to 0x0, 0x4, 0x8 → iValid high for 3 consecutive cycles, data in order.
- Reset (reset = 0) during an ACC_D store → no dValid, mem outputs 0, state IDLE; after release, a fresh load completes normally.
